// File: rtl/inst_sram_resp.sv
// inst_sram_resp: single-cycle-latency instruction SRAM with address checking, read counter and backdoor preload
module inst_sram_resp #(
  parameter logic [31:0] BASE_ADDR = 32'hbfc00000,
  parameter int          AW        = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          inst_sram_en,
  input  logic [3:0]    inst_sram_wen,
  input  logic [31:0]   inst_sram_addr,
  input  logic [31:0]   inst_sram_wdata,
  output logic [31:0]   inst_sram_rdata,
  output logic          rvalid,
  output logic          addr_err,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_idx,
  input  logic [31:0]   ld_data,
  output logic [31:0]   rd_cnt
);
  localparam logic [32:0] LIM = 33'd1 << (AW + 2);
  logic [31:0]   r_mem [2**AW];
  logic [31:0]   w_off;
  logic [AW-1:0] w_idx;
  logic          w_in;
  logic          w_req;
  logic          w_we;
  logic [31:0]   w_old;
  logic [31:0]   w_merged;
  assign w_off = inst_sram_addr - BASE_ADDR;
  assign w_idx = w_off[AW+1:2];
  assign w_in  = inst_sram_addr[1:0] == 2'b00 && inst_sram_addr >= BASE_ADDR && {1'b0, w_off} < LIM;
  assign w_req = inst_sram_en && !reset;
  assign w_we  = w_req && w_in && inst_sram_wen != 4'h0;
  assign w_old = r_mem[w_idx];
  for (genvar g = 0; g < 4; g++) begin : g_lane
    assign w_merged[8*g+:8] = inst_sram_wen[g] ? inst_sram_wdata[8*g+:8] : w_old[8*g+:8];
  end
  // backdoor write is issued last so it overrides an interface write to the same word
  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_idx] <= w_merged;
    if (ld_en) r_mem[ld_idx] <= ld_data;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      inst_sram_rdata <= 32'h0;
      rvalid          <= 1'b0;
      addr_err        <= 1'b0;
      rd_cnt          <= 32'h0;
    end else begin
      rvalid   <= inst_sram_en;
      addr_err <= inst_sram_en && !w_in;
      if (inst_sram_en) inst_sram_rdata <= w_in ? w_old : 32'h0;
      if (inst_sram_en && inst_sram_wen == 4'h0) rd_cnt <= rd_cnt + 32'd1;
    end
  end
endmodule

// File: doc/inst_sram_resp.md
INST_SRAM_RESP -- requirements
Module: inst_sram_resp

Interface
REQ-001 Parameter BASE_ADDR, default 32'hbfc00000, byte address of word 0.
REQ-002 Parameter AW, default 10, word-index width; depth = 2^AW words.
REQ-003 clk  input  1  the only clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high.
REQ-005 inst_sram_en  input  1  access request this cycle.
REQ-006 inst_sram_wen  input  4  byte write enables; 4'h0 means read.
REQ-007 inst_sram_addr  input  32  byte address.
REQ-008 inst_sram_wdata  input  32  write data, byte lane i = bits [8i+7:8i].
REQ-009 inst_sram_rdata  output  32  registered read data.
REQ-010 rvalid  output  1  pulses high for one cycle when inst_sram_rdata carries the response to the previous cycle's request.
REQ-011 addr_err  output  1  pulses high with rvalid when that response came from an out-of-range or misaligned access.
REQ-012 ld_en  input  1  backdoor preload write strobe.
REQ-013 ld_idx  input  AW  backdoor word index.
REQ-014 ld_data  input  32  backdoor full-word data.
REQ-015 rd_cnt  output  32  count of accepted read requests, wraps at 2^32.

Function
REQ-016 Decode: in range iff inst_sram_addr[1:0]==2'b00 and BASE_ADDR <= addr <= BASE_ADDR + 4*2^AW - 4. Word index = (addr - BASE_ADDR) >> 2, low AW bits.
REQ-017 Fixed latency of 1: a request with en=1 at edge N produces rvalid=1 and valid inst_sram_rdata in the cycle after edge N. No stall or backpressure exists.
REQ-018 Read (en=1, wen=4'h0, in range): rdata <= mem[idx]; addr_err <= 0; rd_cnt increments by 1.
REQ-019 Write (en=1, wen!=0, in range): only lanes with wen[i]=1 are updated. Read-first: rdata <= the pre-write word; rd_cnt is unchanged.
REQ-020 Out of range or misaligned (en=1): no memory update; rdata <= 32'h00000000 (MIPS nop); addr_err <= 1; rd_cnt increments only if wen=4'h0.
REQ-021 When en=0: rvalid <= 0, addr_err <= 0, and inst_sram_rdata holds its last value.
REQ-022 Back-to-back requests on consecutive cycles are all served; each gets its own rvalid pulse.
REQ-023 Read of the word written at the previous edge returns the new data (no stale bypass hazard beyond REQ-019).
REQ-024 Backdoor: ld_en=1 writes ld_data to mem[ld_idx] at the edge. It does not affect rdata, rvalid or rd_cnt.
REQ-025 Collision: if ld_en and an in-range interface write target the same word at the same edge, the ld_data word wins entirely. Different words are both written.
REQ-026 Backdoor write and an interface read of the same word at the same edge: the read returns the old word.

Reset
REQ-027 While reset=1 at an edge: inst_sram_rdata <= 32'h0, rvalid <= 0, addr_err <= 0, rd_cnt <= 0.
REQ-028 While reset=1, interface requests are ignored: no memory write and no counting. ld_en remains functional so the bench can preload during reset.
REQ-029 Memory contents are not cleared by reset. A request issued in the cycle before reset asserts produces no rvalid after reset.

Verification
REQ-030 Preload word 0 = 32'h3c080001 during reset; release reset; read 0xbfc00000 -> next cycle rvalid=1, rdata=32'h3c080001, addr_err=0, rd_cnt=1.
REQ-031 Write wen=4'b0101, wdata=32'hAABBCCDD to 0xbfc00004 (old 32'h11223344) -> response rdata=32'h11223344; subsequent read -> 32'h11BB33DD.
REQ-032 Read 0xbfc00002, then 0xbfc00000 + 4*2^AW -> both responses rdata=0, addr_err=1, rd_cnt +2, memory unchanged.
REQ-033 Reads of 0xbfc00000, 0xbfc00004 and 0xbfc00008 on three consecutive cycles -> three consecutive rvalid pulses with words 0, 1, 2 in order; then en=0 -> rvalid=0 and rdata holds word 2.
REQ-034 Same edge: ld_en to idx 3 with 32'h0 and interface write wen=4'hF, 32'hFFFFFFFF to 0xbfc0000c -> later read returns 32'h00000000.
REQ-035 Assert reset mid-stream after rd_cnt=5 -> rd_cnt=0, rvalid=0, rdata=0; previously written words still read back intact.
